y86_mc_core: RTL and testbench

Y86_MC_CORE -- requirements
Module: y86_mc_core

---
 rtl/y86_mc_core.sv | 167 ++++++++++++++++
 tb/tb_y86_mc_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mc_core.sv
// Multi-cycle Y86-style core: FETCH/DECODE/EXEC/MEM/WB sequencer over a single
// shared memory bus, eight general registers, one zero flag.
module y86_mc_core #(
    parameter int             DW       = 32,
    parameter logic [DW-1:0]  RESET_IP = '0,
    parameter int             BASE_REG = 6
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] bus_A,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_RE,
    output logic          bus_WE,
    input  logic          bus_rdy,
    output logic          halted,
    output logic          trap,
    output logic [7:0]    current_opcode
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, STOP} state_t;

    localparam logic [2:0] BASE_IDX = 3'(BASE_REG);

    state_t        state;
    logic [DW-1:0] ip, ir, a, b, mar, mdrw, mdrr, c;
    logic [DW-1:0] r [0:7];
    logic          zf;

    logic [7:0]    opcode, disp8, dist8;
    logic [1:0]    mod;
    logic [2:0]    rd, rs;
    logic          is_load, is_store, is_move, is_add, is_sub, is_jnez, is_halt, legal;
    logic [DW-1:0] ilen, disp_x, dist_x, alu_out, next_ip;

    assign opcode = ir[7:0];
    assign mod    = ir[15:14];
    assign rd     = ir[10:8];
    assign rs     = ir[13:11];
    assign dist8  = ir[15:8];

    // A 16-bit IR has no displacement byte; treat it as zero there.
    generate
        if (DW >= 24) begin : g_disp
            assign disp8 = ir[23:16];
        end else begin : g_nodisp
            assign disp8 = '0;
        end
    endgenerate

    assign disp_x = {{(DW-8){disp8[7]}}, disp8};
    assign dist_x = {{(DW-8){dist8[7]}}, dist8};

    assign is_load  = (opcode == 8'h8B) && (mod == 2'd1);
    assign is_store = (opcode == 8'h89) && (mod == 2'd1);
    assign is_move  = (opcode == 8'h89) && (mod == 2'd3);
    assign is_add   = (opcode == 8'h01);
    assign is_sub   = (opcode == 8'h29);
    assign is_jnez  = (opcode == 8'h75);
    assign is_halt  = (opcode == 8'hF4);
    assign legal    = is_load | is_store | is_move | is_add | is_sub | is_jnez | is_halt;

    // Instruction length, ALU result and sequential next IP
    always_comb begin
        ilen = DW'(2);
        if (is_load || is_store) ilen = DW'(3);
        else if (is_halt)        ilen = DW'(1);

        alu_out = '0;
        if (is_load || is_store) alu_out = a + disp_x;
        else if (is_add)         alu_out = a + b;
        else if (is_sub)         alu_out = a - b;

        next_ip = ip + ilen + ((is_jnez && !zf) ? dist_x : '0);
    end

    // Bus strobes and address; everything idles to zero outside an access or in reset
    always_comb begin
        bus_A  = '0;
        bus_RE = 1'b0;
        bus_WE = 1'b0;
        if (!rst) begin
            if (state == FETCH) begin
                bus_A  = ip;
                bus_RE = 1'b1;
            end else if (state == MEM && is_load) begin
                bus_A  = mar;
                bus_RE = 1'b1;
            end else if (state == MEM && is_store) begin
                bus_A  = mar;
                bus_WE = 1'b1;
            end
        end
    end

    assign bus_out        = mdrw;
    assign current_opcode = ir[7:0];

    // Sequencer and all architectural / micro-architectural state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            ip     <= RESET_IP;
            zf     <= 1'b0;
            halted <= 1'b0;
            trap   <= 1'b0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            mar    <= '0;
            mdrw   <= '0;
            mdrr   <= '0;
            c      <= '0;
            for (int unsigned i = 0; i < 8; i++) r[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus_rdy) begin
                        ir    <= bus_in;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a <= r[(is_load || is_store) ? BASE_IDX : rd];
                    b <= r[rs];
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= STOP;
                    end else if (!legal) begin
                        trap  <= 1'b1;
                        state <= STOP;
                    end else begin
                        ip    <= next_ip;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    mar  <= alu_out;
                    c    <= is_move ? b : alu_out;
                    mdrw <= b;
                    if (is_add || is_sub) zf <= (alu_out == '0);
                    state <= MEM;
                end
                MEM: begin
                    if (is_load) begin
                        if (bus_rdy) begin
                            mdrr  <= bus_in;
                            state <= WB;
                        end
                    end else if (is_store) begin
                        if (bus_rdy) state <= WB;
                    end else begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (is_load)                        r[rs] <= mdrr;
                    else if (is_add || is_sub || is_move) r[rd] <= c;
                    state <= FETCH;
                end
                STOP: state <= STOP;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_mc_core.sv
// Directed bench for y86_mc_core: a short program exercising every instruction,
// bus wait states, halt/trap stops, reset mid-access, and 16-bit IP wrap.
module tb_y86_mc_core;

    logic        clk = 1'b0;
    logic        rst, bus_rdy;
    logic [31:0] bus_A, bus_in, bus_out;
    logic        bus_RE, bus_WE, halted, trap;
    logic [7:0]  current_opcode;

    logic        rst16;
    logic [15:0] a16, in16, out16;
    logic        re16, we16, h16, t16;
    logic [7:0]  op16;

    logic [31:0] mem [0:511];

    int n_checks = 0;
    int n_errors = 0;
    int we_cycles = 0, strobe_cycles = 0, both_cycles = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    int snap;

    always #5 clk = ~clk;

    assign bus_in = mem[bus_A[8:0]];
    assign in16   = 16'hD101;

    y86_mc_core #(.DW(32), .RESET_IP(32'h0), .BASE_REG(6)) dut (
        .clk(clk), .rst(rst), .bus_A(bus_A), .bus_in(bus_in), .bus_out(bus_out),
        .bus_RE(bus_RE), .bus_WE(bus_WE), .bus_rdy(bus_rdy), .halted(halted),
        .trap(trap), .current_opcode(current_opcode)
    );

    y86_mc_core #(.DW(16), .RESET_IP(16'hFFFF), .BASE_REG(6)) dut16 (
        .clk(clk), .rst(rst16), .bus_A(a16), .bus_in(in16), .bus_out(out16),
        .bus_RE(re16), .bus_WE(we16), .bus_rdy(1'b1), .halted(h16),
        .trap(t16), .current_opcode(op16)
    );

    always @(negedge clk) begin
        if (bus_WE) begin
            we_cycles++;
            wr_addr = bus_A;
            wr_data = bus_out;
        end
        if (bus_RE || bus_WE) strobe_cycles++;
        if (bus_RE && bus_WE) both_cycles++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        // program
        mem[0]  = 32'h504E8B; // load R1,[R6+0x50]
        mem[3]  = 32'h51568B; // load R2,[R6+0x51]
        mem[6]  = 32'h00D101; // add  R1,R2
        mem[8]  = 32'h524E8B; // load R1,[R6+0x52]
        mem[11] = 32'h52568B; // load R2,[R6+0x52]
        mem[14] = 32'h00D129; // sub  R1,R2
        mem[16] = 32'h00FC75; // jnez -4
        mem[18] = 32'h524E8B; // load R1,[R6+0x52]
        mem[21] = 32'h53568B; // load R2,[R6+0x53]
        mem[24] = 32'h00D129; // sub  R1,R2
        mem[26] = 32'h545E8B; // load R3,[R6+0x54]
        mem[29] = 32'h00FC75; // jnez -4 -> 27
        mem[27] = 32'h55768B; // load R6,[R6+0x55]
        mem[30] = 32'hF85E8B; // load R3,[R6-8]
        mem[33] = 32'h10768B; // load R6,[R6+0x10]
        mem[36] = 32'h00468B; // load R0,[R6+0]
        mem[39] = 32'h044689; // store R0,[R6+4]
        mem[42] = 32'h00DD89; // move R5,R3
        mem[44] = 32'h0000F4; // halt
        // data
        mem[9'h50]  = 32'd5;
        mem[9'h51]  = 32'd7;
        mem[9'h52]  = 32'd9;
        mem[9'h53]  = 32'd8;
        mem[9'h54]  = 32'h77;
        mem[9'h55]  = 32'h100;
        mem[9'h0F8] = 32'hDEAD;
        mem[9'h110] = 32'h40;
        mem[9'h040] = 32'h1234;

        rst = 1'b1; rst16 = 1'b1; bus_rdy = 1'b1;
        run(2);
        chk("rst_re", bus_RE, 0);
        chk("rst_we", bus_WE, 0);
        chk("rst_a", bus_A, 0);
        chk("rst_halted", halted, 0);
        chk("rst_trap", trap, 0);
        chk("rst_ip", dut.ip, 0);
        rst = 1'b0; rst16 = 1'b0;
        #1;
        chk("fetch0_re", bus_RE, 1);
        chk("fetch0_a", bus_A, 0);
        chk("dw16_reset_ip", a16, 16'hFFFF);

        run(5);
        chk("load1_next", bus_A, 3);
        chk("load1_r1", dut.r[1], 5);
        chk("dw16_wrap", a16, 16'h0001);
        run(5);
        chk("load2_r2", dut.r[2], 7);
        run(5);
        chk("add_next_ip", bus_A, 8);
        chk("add_r1", dut.r[1], 12);
        chk("add_zf", dut.zf, 0);

        run(15);
        chk("sub0_r1", dut.r[1], 0);
        chk("sub0_zf", dut.zf, 1);
        chk("sub0_next", bus_A, 16);
        run(5);
        chk("jnez_not_taken", bus_A, 18);

        run(15);
        chk("sub1_r1", dut.r[1], 1);
        chk("sub1_zf", dut.zf, 0);
        run(5);
        chk("load_r3_pre", dut.r[3], 32'h77);
        run(5);
        chk("jnez_taken", bus_A, 27);
        run(5);
        chk("load_r6", dut.r[6], 32'h100);

        // load with three wait cycles in MEM
        run(3);
        bus_rdy = 1'b0;
        chk("ld_mem_a", bus_A, 32'hF8);
        chk("ld_mem_re", bus_RE, 1);
        run(3);
        chk("ld_wait_a", bus_A, 32'hF8);
        chk("ld_wait_re", bus_RE, 1);
        bus_rdy = 1'b1;
        run(2);
        chk("ld_slow_next", bus_A, 33);
        chk("ld_slow_r3", dut.r[3], 32'hDEAD);

        run(10);
        chk("load_r0", dut.r[0], 32'h1234);
        chk("load_r6b", dut.r[6], 32'h40);

        run(3);
        chk("st_we", bus_WE, 1);
        chk("st_re", bus_RE, 0);
        chk("st_a", bus_A, 32'h44);
        chk("st_out", bus_out, 32'h1234);
        run(2);
        chk("st_we_cycles", we_cycles, 1);
        chk("st_wr_addr", wr_addr, 32'h44);
        chk("st_next", bus_A, 42);

        run(5);
        chk("move_r5", dut.r[5], 32'hDEAD);
        chk("move_next", bus_A, 44);

        run(2);
        chk("halt_halted", halted, 1);
        chk("halt_trap", trap, 0);
        chk("halt_opcode", current_opcode, 8'hF4);
        snap = strobe_cycles;
        run(10);
        chk("halt_no_strobe", strobe_cycles, snap);
        chk("halt_ip", dut.ip, 44);
        chk("halt_held", halted, 1);

        // reset out of STOP, then reset during a FETCH wait
        rst = 1'b1;
        run(1);
        chk("rst2_re", bus_RE, 0);
        chk("rst2_halted", halted, 0);
        chk("rst2_r5", dut.r[5], 0);
        bus_rdy = 1'b0;
        rst = 1'b0;
        #1;
        run(2);
        chk("fwait_re", bus_RE, 1);
        chk("fwait_a", bus_A, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_re", bus_RE, 0);
        run(1);
        rst = 1'b0;
        #1;
        chk("rst_mid_ip", dut.ip, 0);
        chk("rst_mid_a", bus_A, 0);
        chk("rst_mid_fetch", bus_RE, 1);

        // illegal opcode
        mem[0] = 32'hFF;
        bus_rdy = 1'b1;
        run(2);
        chk("trap_set", trap, 1);
        chk("trap_halted", halted, 0);
        chk("trap_ip", dut.ip, 0);
        chk("trap_opcode", current_opcode, 8'hFF);
        snap = strobe_cycles;
        run(4);
        chk("trap_no_strobe", strobe_cycles, snap);
        chk("trap_held", trap, 1);

        chk("re_we_exclusive", both_cycles, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
